// File: rtl/iob_soc_sut_mem_arbiter_pkg.sv
// Shared definitions for the two-master external-memory arbiter.
//   - FSM state encoding (IDLE / REQ / RESP)
//   - number of requesters sharing the memory port
package iob_soc_sut_mem_arbiter_pkg;

    localparam int NUM_MASTERS = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,  // nobody granted, waiting for a request
        REQ  = 2'd1,  // request of master sel forwarded to memory
        RESP = 2'd2   // read accepted, waiting for memory read data
    } state_t;

endpackage

// File: rtl/iob_reg.sv
// Generic register with asynchronous active-high reset and clock enable.
// Ports:
//   clk_i   - clock
//   arst_i  - asynchronous reset, loads RST_VAL
//   cke_i   - clock enable; register holds while low
//   data_i  - next value
//   data_o  - registered value
module iob_reg #(
    parameter int                DATA_W  = 1,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic              cke_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o
);

    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            data_q <= RST_VAL;
        end else if (cke_i) begin
            data_q <= data_i;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/iob_soc_sut_mem_arbiter_rr_pick.sv
// Combinational round-robin next-owner selection.
// Ports:
//   valid_i - request valids, bit N = master N
//   last_i  - master served most recently
//   sel_o   - master to grant next (only meaningful when any valid is high)
module iob_soc_sut_rr_pick
    import iob_soc_sut_mem_arbiter_pkg::*;
(
    input  logic [NUM_MASTERS-1:0] valid_i,
    input  logic                   last_i,
    output logic                   sel_o
);

    // A lone requester always wins; on a tie the master that was not
    // served last gets the port, which is what keeps a streaming master
    // from starving the other one.
    always_comb begin
        sel_o = 1'b0;
        unique case (valid_i)
            2'b01:   sel_o = 1'b0;
            2'b10:   sel_o = 1'b1;
            2'b11:   sel_o = ~last_i;
            default: sel_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/iob_soc_sut_mem_arbiter.sv
// Two-master round-robin arbiter sharing one IOb-native memory port.
// Master 0 is the SUT cache back-end, master 1 a DMA peripheral. Only one
// transaction is in flight; a read keeps the grant until its data returns.
// Ports:
//   clk_i, cke_i, arst_i      - clock, clock enable, async active-high reset
//   mN_iob_*_i / mN_iob_*_o   - IOb-native slave ports for master 0 and 1
//   s_iob_*_o / s_iob_*_i     - IOb-native master port towards memory
//   grant_o                   - one-hot current owner, 0 while idle
module iob_soc_sut_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk_i,
    input  logic                  cke_i,
    input  logic                  arst_i,

    input  logic                  m0_iob_valid_i,
    input  logic [ADDR_W-1:0]     m0_iob_addr_i,
    input  logic [DATA_W-1:0]     m0_iob_wdata_i,
    input  logic [DATA_W/8-1:0]   m0_iob_wstrb_i,
    output logic                  m0_iob_ready_o,
    output logic                  m0_iob_rvalid_o,
    output logic [DATA_W-1:0]     m0_iob_rdata_o,

    input  logic                  m1_iob_valid_i,
    input  logic [ADDR_W-1:0]     m1_iob_addr_i,
    input  logic [DATA_W-1:0]     m1_iob_wdata_i,
    input  logic [DATA_W/8-1:0]   m1_iob_wstrb_i,
    output logic                  m1_iob_ready_o,
    output logic                  m1_iob_rvalid_o,
    output logic [DATA_W-1:0]     m1_iob_rdata_o,

    output logic                  s_iob_valid_o,
    output logic [ADDR_W-1:0]     s_iob_addr_o,
    output logic [DATA_W-1:0]     s_iob_wdata_o,
    output logic [DATA_W/8-1:0]   s_iob_wstrb_o,
    input  logic                  s_iob_ready_i,
    input  logic                  s_iob_rvalid_i,
    input  logic [DATA_W-1:0]     s_iob_rdata_i,

    output logic [1:0]            grant_o
);

    import iob_soc_sut_mem_arbiter_pkg::*;

    localparam int STRB_W = DATA_W / 8;

    logic [1:0]             state_q, state_d;
    logic                   sel_q, sel_d;
    logic                   last_q, last_d;
    logic                   pick_sel;

    logic [NUM_MASTERS-1:0] m_valid;
    logic [ADDR_W-1:0]      m_addr  [NUM_MASTERS];
    logic [DATA_W-1:0]      m_wdata [NUM_MASTERS];
    logic [STRB_W-1:0]      m_wstrb [NUM_MASTERS];
    logic [NUM_MASTERS-1:0] m_ready;
    logic [NUM_MASTERS-1:0] m_rvalid;
    logic [NUM_MASTERS-1:0] grant;

    // Gather the discrete master ports into indexable arrays.
    assign m_valid    = {m1_iob_valid_i, m0_iob_valid_i};
    assign m_addr[0]  = m0_iob_addr_i;
    assign m_addr[1]  = m1_iob_addr_i;
    assign m_wdata[0] = m0_iob_wdata_i;
    assign m_wdata[1] = m1_iob_wdata_i;
    assign m_wstrb[0] = m0_iob_wstrb_i;
    assign m_wstrb[1] = m1_iob_wstrb_i;

    // Read data is shared; rvalid alone tells a master the data is for it.
    assign m0_iob_rdata_o  = s_iob_rdata_i;
    assign m1_iob_rdata_o  = s_iob_rdata_i;
    assign m0_iob_ready_o  = m_ready[0];
    assign m1_iob_ready_o  = m_ready[1];
    assign m0_iob_rvalid_o = m_rvalid[0];
    assign m1_iob_rvalid_o = m_rvalid[1];
    assign grant_o         = grant;

    iob_soc_sut_rr_pick u_pick (
        .valid_i (m_valid),
        .last_i  (last_q),
        .sel_o   (pick_sel)
    );

    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        last_d        = last_q;
        s_iob_valid_o = 1'b0;
        s_iob_addr_o  = '0;
        s_iob_wdata_o = '0;
        s_iob_wstrb_o = '0;
        m_ready       = '0;
        m_rvalid      = '0;
        grant         = '0;

        case (state_q)
            IDLE: begin
                if (|m_valid) begin
                    sel_d   = pick_sel;
                    state_d = REQ;
                end
            end

            REQ: begin
                grant[sel_q]   = 1'b1;
                s_iob_valid_o  = m_valid[sel_q];
                s_iob_addr_o   = m_addr[sel_q];
                s_iob_wdata_o  = m_wdata[sel_q];
                s_iob_wstrb_o  = m_wstrb[sel_q];
                m_ready[sel_q] = s_iob_ready_i;
                if (!m_valid[sel_q]) begin
                    // Requester withdrew before acceptance: abandon the
                    // slot without counting it as served.
                    state_d = IDLE;
                end else if (s_iob_ready_i) begin
                    if (|m_wstrb[sel_q]) begin
                        last_d  = sel_q;
                        state_d = IDLE;
                    end else begin
                        state_d = RESP;
                    end
                end
            end

            RESP: begin
                grant[sel_q] = 1'b1;
                if (s_iob_rvalid_i) begin
                    m_rvalid[sel_q] = 1'b1;
                    last_d          = sel_q;
                    state_d         = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    iob_reg #(.DATA_W(2), .RST_VAL(IDLE)) u_state_reg (
        .clk_i  (clk_i),
        .arst_i (arst_i),
        .cke_i  (cke_i),
        .data_i (state_d),
        .data_o (state_q)
    );

    iob_reg #(.DATA_W(1), .RST_VAL(1'b0)) u_sel_reg (
        .clk_i  (clk_i),
        .arst_i (arst_i),
        .cke_i  (cke_i),
        .data_i (sel_d),
        .data_o (sel_q)
    );

    // Reset to 1 so master 0 wins the first tie after reset.
    iob_reg #(.DATA_W(1), .RST_VAL(1'b1)) u_last_reg (
        .clk_i  (clk_i),
        .arst_i (arst_i),
        .cke_i  (cke_i),
        .data_i (last_d),
        .data_o (last_q)
    );

endmodule

// File: tb/tb_iob_soc_sut_mem_arbiter.sv
module tb_iob_soc_sut_mem_arbiter;

    logic        clk = 1'b0;
    logic        cke = 1'b1;
    logic        arst = 1'b1;

    logic        m0_valid = 0, m1_valid = 0;
    logic [31:0] m0_addr = 0, m1_addr = 0, m0_wdata = 0, m1_wdata = 0;
    logic [3:0]  m0_wstrb = 0, m1_wstrb = 0;
    logic        m0_ready, m1_ready, m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;

    logic        s_valid;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_ready = 0, s_rvalid = 0;
    logic [31:0] s_rdata = 0;
    logic [1:0]  grant;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    always #5 clk = ~clk;

    iob_soc_sut_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk_i           (clk),
        .cke_i           (cke),
        .arst_i          (arst),
        .m0_iob_valid_i  (m0_valid),
        .m0_iob_addr_i   (m0_addr),
        .m0_iob_wdata_i  (m0_wdata),
        .m0_iob_wstrb_i  (m0_wstrb),
        .m0_iob_ready_o  (m0_ready),
        .m0_iob_rvalid_o (m0_rvalid),
        .m0_iob_rdata_o  (m0_rdata),
        .m1_iob_valid_i  (m1_valid),
        .m1_iob_addr_i   (m1_addr),
        .m1_iob_wdata_i  (m1_wdata),
        .m1_iob_wstrb_i  (m1_wstrb),
        .m1_iob_ready_o  (m1_ready),
        .m1_iob_rvalid_o (m1_rvalid),
        .m1_iob_rdata_o  (m1_rdata),
        .s_iob_valid_o   (s_valid),
        .s_iob_addr_o    (s_addr),
        .s_iob_wdata_o   (s_wdata),
        .s_iob_wstrb_o   (s_wstrb),
        .s_iob_ready_i   (s_ready),
        .s_iob_rvalid_i  (s_rvalid),
        .s_iob_rdata_i   (s_rdata),
        .grant_o         (grant)
    );

    // Advance one clock; inputs are driven and outputs sampled 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_cnt++; if (grant !== 2'b00) $display("FAIL rst_grant: got %b want 00", grant); else pass_cnt++;
        chk_cnt++; if (s_valid !== 1'b0) $display("FAIL rst_s_valid: got %b want 0", s_valid); else pass_cnt++;
        arst = 1'b0;
        // rvalid outside RESP must be ignored, rdata still passes through.
        s_rvalid = 1'b1; s_rdata = 32'h0BAD_F00D;
        #1;
        chk_cnt++; if ({m1_rvalid, m0_rvalid} !== 2'b00) $display("FAIL idle_rvalid_ignored: got %b want 00", {m1_rvalid, m0_rvalid}); else pass_cnt++;
        chk_cnt++; if (m0_rdata !== 32'h0BAD_F00D) $display("FAIL rdata_passthru: got %h want 0badf00d", m0_rdata); else pass_cnt++;
        step();
        s_rvalid = 1'b0;
        $display("reset: done");
    endtask

    task automatic test_single_write();
        m0_valid = 1; m0_addr = 32'h100; m0_wdata = 32'hDEAD_BEEF; m0_wstrb = 4'hF;
        #1;
        chk_cnt++; if (s_valid !== 1'b0) $display("FAIL wr_c0_s_valid: got %b want 0", s_valid); else pass_cnt++;
        step();  // cycle 1, REQ
        chk_cnt++; if (s_valid !== 1'b1) $display("FAIL wr_c1_s_valid: got %b want 1", s_valid); else pass_cnt++;
        chk_cnt++; if ({s_addr, s_wdata, s_wstrb} !== {32'h100, 32'hDEAD_BEEF, 4'hF})
            $display("FAIL wr_fwd: got %h/%h/%h want 100/deadbeef/f", s_addr, s_wdata, s_wstrb); else pass_cnt++;
        chk_cnt++; if (grant !== 2'b01) $display("FAIL wr_grant: got %b want 01", grant); else pass_cnt++;
        chk_cnt++; if (m0_ready !== 1'b0) $display("FAIL wr_c1_ready: got %b want 0", m0_ready); else pass_cnt++;
        step();  // cycle 2, memory accepts
        s_ready = 1;
        #1;
        chk_cnt++; if ({m1_ready, m0_ready} !== 2'b01) $display("FAIL wr_c2_ready: got %b want 01", {m1_ready, m0_ready}); else pass_cnt++;
        chk_cnt++; if ({m1_rvalid, m0_rvalid} !== 2'b00) $display("FAIL wr_rvalid: got %b want 00", {m1_rvalid, m0_rvalid}); else pass_cnt++;
        step();
        s_ready = 0; m0_valid = 0;
        #1;
        chk_cnt++; if ({grant, s_valid, s_addr} !== {2'b00, 1'b0, 32'h0})
            $display("FAIL wr_idle: got grant %b valid %b addr %h want 00/0/0", grant, s_valid, s_addr); else pass_cnt++;
        $display("single_write: m0 wr 0x100 done");
    endtask

    task automatic test_single_read();
        m1_valid = 1; m1_addr = 32'h40; m1_wstrb = 4'h0;
        step();  // REQ
        chk_cnt++; if ({grant, s_addr, s_wstrb} !== {2'b10, 32'h40, 4'h0})
            $display("FAIL rd_req: got grant %b addr %h wstrb %h want 10/40/0", grant, s_addr, s_wstrb); else pass_cnt++;
        s_ready = 1;
        #1;
        chk_cnt++; if ({m1_ready, m0_ready} !== 2'b10) $display("FAIL rd_ready: got %b want 10", {m1_ready, m0_ready}); else pass_cnt++;
        step();  // RESP
        s_ready = 0; m1_valid = 0;
        #1;
        chk_cnt++; if ({grant, s_valid} !== {2'b10, 1'b0}) $display("FAIL rd_resp: got grant %b valid %b want 10/0", grant, s_valid); else pass_cnt++;
        step();
        step();  // third cycle after acceptance
        chk_cnt++; if (m1_rvalid !== 1'b0) $display("FAIL rd_early_rvalid: got %b want 0", m1_rvalid); else pass_cnt++;
        s_rvalid = 1; s_rdata = 32'h1234_5678;
        #1;
        chk_cnt++; if ({m1_rvalid, m0_rvalid, m1_rdata} !== {2'b10, 32'h1234_5678})
            $display("FAIL rd_data: got rv %b%b data %h want 10/12345678", m1_rvalid, m0_rvalid, m1_rdata); else pass_cnt++;
        chk_cnt++; if (grant !== 2'b10) $display("FAIL rd_grant_resp: got %b want 10", grant); else pass_cnt++;
        step();
        s_rvalid = 0;
        #1;
        chk_cnt++; if ({grant, m1_rvalid} !== 3'b000) $display("FAIL rd_done: got grant %b rvalid %b want 00/0", grant, m1_rvalid); else pass_cnt++;
        $display("single_read: m1 rd 0x40 -> 12345678");
    endtask

    task automatic test_tie();
        arst = 1; #1; arst = 0;  // fresh reset: last points to m1
        m0_valid = 1; m0_addr = 32'h200; m0_wstrb = 4'hF;
        m1_valid = 1; m1_addr = 32'h300; m1_wstrb = 4'hF;
        step();
        chk_cnt++; if ({grant, s_addr} !== {2'b01, 32'h200}) $display("FAIL tie_first: got %b/%h want 01/200", grant, s_addr); else pass_cnt++;
        s_ready = 1;
        step();
        s_ready = 0; m0_valid = 0;
        #1;
        chk_cnt++; if (grant !== 2'b00) $display("FAIL tie_gap: got %b want 00", grant); else pass_cnt++;
        step();
        chk_cnt++; if ({grant, s_addr} !== {2'b10, 32'h300}) $display("FAIL tie_second: got %b/%h want 10/300", grant, s_addr); else pass_cnt++;
        s_ready = 1;
        step();
        s_ready = 0; m1_valid = 0;
        $display("tie: order m0 then m1");
    endtask

    task automatic test_back_to_back();
        int m0_n = 0;
        logic owner;
        // last = m1 here, so m0 takes the first tie.
        m0_valid = 1; m0_addr = 32'h10; m0_wstrb = 4'hF;
        m1_valid = 1; m1_addr = 32'h80; m1_wstrb = 4'h0;
        for (int t = 0; t < 5; t++) begin
            owner = (t == 1);
            #1;
            chk_cnt++; if (grant !== 2'b00) $display("FAIL b2b_idle%0d: got %b want 00", t, grant); else pass_cnt++;
            step();
            chk_cnt++; if (grant !== (owner ? 2'b10 : 2'b01)) $display("FAIL b2b_owner%0d: got %b want %b", t, grant, owner ? 2'b10 : 2'b01); else pass_cnt++;
            chk_cnt++; if (s_addr !== (owner ? 32'h80 : 32'h10 + 32'(4 * m0_n))) $display("FAIL b2b_addr%0d: got %h", t, s_addr); else pass_cnt++;
            s_ready = 1;
            step();
            s_ready = 0;
            if (owner) begin
                m1_valid = 0;
                step();
                s_rvalid = 1; s_rdata = 32'hCAFE_F00D;
                #1;
                chk_cnt++; if ({m1_rvalid, m0_rvalid, m1_rdata} !== {2'b10, 32'hCAFE_F00D})
                    $display("FAIL b2b_rdata: got %b%b %h want 10 cafef00d", m1_rvalid, m0_rvalid, m1_rdata); else pass_cnt++;
                step();
                s_rvalid = 0;
            end else begin
                m0_n++;
                if (m0_n == 4) m0_valid = 0;
                else m0_addr = 32'h10 + 32'(4 * m0_n);
            end
            $display("back_to_back: tx %0d served m%0d", t, owner);
        end
    endtask

    task automatic test_reset_in_resp();
        // last = m0 here; without reset the next tie would go to m1.
        m0_valid = 1; m0_addr = 32'h500; m0_wstrb = 4'h0;
        step();
        s_ready = 1;
        step();  // RESP
        s_ready = 0; m0_valid = 0;
        #1;
        chk_cnt++; if (grant !== 2'b01) $display("FAIL rr_resp_grant: got %b want 01", grant); else pass_cnt++;
        arst = 1;
        #1;
        chk_cnt++; if ({grant, s_valid} !== 3'b000) $display("FAIL rr_async: got %b/%b want 00/0", grant, s_valid); else pass_cnt++;
        step();
        arst = 0;
        s_rvalid = 1; s_rdata = 32'h5555_AAAA;
        #1;
        chk_cnt++; if ({m1_rvalid, m0_rvalid} !== 2'b00) $display("FAIL rr_late_rvalid: got %b want 00", {m1_rvalid, m0_rvalid}); else pass_cnt++;
        step();
        s_rvalid = 0;
        m0_valid = 1; m0_addr = 32'h700; m0_wstrb = 4'hF;
        m1_valid = 1; m1_addr = 32'h710; m1_wstrb = 4'hF;
        step();
        chk_cnt++; if (grant !== 2'b01) $display("FAIL rr_tie_after: got %b want 01", grant); else pass_cnt++;
        s_ready = 1;
        step();
        m0_valid = 0; s_ready = 0;
        step();
        s_ready = 1;
        step();
        m1_valid = 0; s_ready = 0;
        $display("reset_in_resp: late rvalid dropped");
    endtask

    task automatic test_cke_freeze();
        m1_valid = 1; m1_addr = 32'h600; m1_wdata = 32'hA5A5_A5A5; m1_wstrb = 4'h3;
        step();  // REQ for m1
        cke = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_cnt++; if ({grant, s_valid, s_addr, s_wdata} !== {2'b10, 1'b1, 32'h600, 32'hA5A5_A5A5})
                $display("FAIL cke_hold%0d: got %b/%b/%h/%h", i, grant, s_valid, s_addr, s_wdata); else pass_cnt++;
        end
        // Acceptance while frozen forwards ready but must not move the FSM.
        s_ready = 1;
        #1;
        chk_cnt++; if (m1_ready !== 1'b1) $display("FAIL cke_fwd_ready: got %b want 1", m1_ready); else pass_cnt++;
        step();
        s_ready = 0; cke = 1;
        #1;
        chk_cnt++; if (grant !== 2'b10) $display("FAIL cke_frozen_state: got %b want 10", grant); else pass_cnt++;
        s_ready = 1;
        step();
        s_ready = 0; m1_valid = 0;
        #1;
        chk_cnt++; if (grant !== 2'b00) $display("FAIL cke_complete: got %b want 00", grant); else pass_cnt++;
        $display("cke_freeze: m1 wr 0x600 completed after thaw");
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_tie();
        test_back_to_back();
        test_reset_in_resp();
        test_cke_freeze();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
